// File: rtl/sram_responder.sv
// On-chip 16-bit memory target answering the SLC-3 control unit's active-low SRAM strobes.
// Latches each access on strobe assertion, commits byte-lane writes, returns registered read data.
module sram_responder #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       Data_in,
    output logic [15:0]       Data_out,
    output logic              Data_valid,
    output logic              Ready,
    output logic              Err_conflict
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_COMMIT,
        HOLD
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t            state;
    logic [15:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              ub_q;
    logic              lb_q;
    logic [1:0]        cnt;
    logic              req;
    logic [15:0]       rd_word;

    assign req     = !Mem_CE && (!Mem_OE || !Mem_WE);
    // A waiting read uses the address latched at request time; an immediate read uses the live bus.
    assign rd_word = mem[(state == RD_WAIT) ? addr_q : Addr];

    function automatic logic [15:0] lane_mask(input logic [15:0] w, input logic ub, input logic lb);
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            Data_out     <= 16'h0000;
            Data_valid   <= 1'b0;
            Ready        <= 1'b1;
            Err_conflict <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            ub_q         <= 1'b1;
            lb_q         <= 1'b1;
            cnt          <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!Mem_WE) begin
                            addr_q  <= Addr;
                            wdata_q <= Data_in;
                            ub_q    <= Mem_UB;
                            lb_q    <= Mem_LB;
                            if (!Mem_OE) Err_conflict <= 1'b1;
                            state   <= WR_COMMIT;
                        end else if (LAT == 2'd0) begin
                            Data_out   <= lane_mask(rd_word, Mem_UB, Mem_LB);
                            Data_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            addr_q <= Addr;
                            ub_q   <= Mem_UB;
                            lb_q   <= Mem_LB;
                            cnt    <= LAT;
                            Ready  <= 1'b0;
                            state  <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (Mem_OE || Mem_CE) begin
                        Ready <= 1'b1;
                        state <= IDLE;
                    end else if (Mem_WE) begin
                        // Loading on the last count puts data out exactly RD_LAT edges after the request.
                        if (cnt <= 2'd1) begin
                            Data_out   <= lane_mask(rd_word, ub_q, lb_q);
                            Data_valid <= 1'b1;
                            Ready      <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                end
                WR_COMMIT: state <= HOLD;
                HOLD: begin
                    if (Mem_CE || (Mem_OE && Mem_WE)) begin
                        Data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a reset during WR_COMMIT still blocks
    // the write because the state register leaves WR_COMMIT asynchronously.
    always_ff @(posedge Clk) begin
        if (state == WR_COMMIT) begin
            if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
            if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: one instance with RD_LAT=0 and one with RD_LAT=2 share the bus,
// and a word-level memory model predicts every read.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1, Mem_UB = 1'b1, Mem_LB = 1'b1;
    logic [7:0]  Addr = 8'h00;
    logic [15:0] Data_in = 16'h0000;
    logic [15:0] dout0, dout2;
    logic        valid0, valid2, ready0, ready2, err0, err2;

    int total = 0;
    int bad   = 0;

    logic [15:0] model_mem [0:255];
    logic [7:0]  addr_list [0:7];

    sram_responder #(.ADDR_W(8), .RD_LAT(0)) u_lat0 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Addr(Addr), .Data_in(Data_in),
        .Data_out(dout0), .Data_valid(valid0), .Ready(ready0), .Err_conflict(err0)
    );

    sram_responder #(.ADDR_W(8), .RD_LAT(2)) u_lat2 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Addr(Addr), .Data_in(Data_in),
        .Data_out(dout2), .Data_valid(valid2), .Ready(ready2), .Err_conflict(err2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] exp_rd(input logic [7:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        w = model_mem[a];
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic ub, input logic lb);
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; Mem_UB = ub; Mem_LB = lb;
        Addr = a; Data_in = d;
        tick(); tick();
        bus_idle();
        tick(); tick();
        if (!ub) model_mem[a][15:8] = d[15:8];
        if (!lb) model_mem[a][7:0]  = d[7:0];
    endtask

    // Two-cycle OE read as the control unit issues it; the RD_LAT=2 instance aborts after one wait cycle.
    task automatic do_read0(input logic [7:0] a, input logic ub, input logic lb,
                            output logic [15:0] d, output logic v);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb; Addr = a;
        tick();
        d = dout0; v = valid0;
        tick();
        bus_idle();
        tick(); tick();
    endtask

    // Three-cycle OE read long enough for the RD_LAT=2 instance to complete.
    task automatic do_read2(input logic [7:0] a, input logic ub, input logic lb,
                            output logic [15:0] d0, output logic v0,
                            output logic [15:0] d2, output logic v2, output logic [2:0] rdy);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb; Addr = a;
        tick(); rdy[2] = ready2;
        tick(); rdy[1] = ready2;
        tick(); rdy[0] = ready2;
        d0 = dout0; v0 = valid0; d2 = dout2; v2 = valid2;
        bus_idle();
        tick(); tick();
    endtask

    task automatic test_reset();
        bus_idle();
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({dout0, valid0, ready0, err0} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_lat0: got d=%h v=%b r=%b e=%b expected d=0000 v=0 r=1 e=0", dout0, valid0, ready0, err0);
        end
        total++;
        if ({dout2, valid2, ready2, err2} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_lat2: got d=%h v=%b r=%b e=%b expected d=0000 v=0 r=1 e=0", dout2, valid2, ready2, err2);
        end
        tick(); tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(8'h3A, 16'hBEEF, 1'b0, 1'b0);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0; Addr = 8'h3A;
        tick();
        total++;
        if ({dout0, valid0} !== {16'hBEEF, 1'b1}) begin
            bad++;
            $display("FAIL write_read_first: got d=%h v=%b expected d=beef v=1", dout0, valid0);
        end
        tick();
        total++;
        if ({dout0, valid0} !== {16'hBEEF, 1'b1}) begin
            bad++;
            $display("FAIL write_read_hold: got d=%h v=%b expected d=beef v=1", dout0, valid0);
        end
        bus_idle();
        tick();
        total++;
        if (valid0 !== 1'b0) begin
            bad++;
            $display("FAIL valid_clear_on_exit: got v=%b expected v=0", valid0);
        end
        tick();
    endtask

    task automatic test_lanes();
        logic [15:0] d;
        logic        v;
        do_write(8'h05, 16'h1234, 1'b0, 1'b0);
        do_write(8'h05, 16'hAB00, 1'b0, 1'b1);
        do_read0(8'h05, 1'b0, 1'b0, d, v);
        total++;
        if ({d, v} !== {16'hAB34, 1'b1}) begin
            bad++;
            $display("FAIL lanes_both: got d=%h v=%b expected d=ab34 v=1", d, v);
        end
        do_read0(8'h05, 1'b1, 1'b0, d, v);
        total++;
        if ({d, v} !== {16'h0034, 1'b1}) begin
            bad++;
            $display("FAIL lanes_lower_only: got d=%h v=%b expected d=0034 v=1", d, v);
        end
    endtask

    task automatic test_ce_high();
        logic [15:0] d;
        logic        v;
        Mem_CE = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Addr = 8'h3A; Data_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({valid0, valid2, ready2, err0, err2} !== 5'b00100) begin
                bad++;
                $display("FAIL ce_high_cycle%0d: got v0=%b v2=%b r2=%b e0=%b e2=%b expected 0 0 1 0 0",
                         i, valid0, valid2, ready2, err0, err2);
            end
        end
        bus_idle();
        tick();
        do_read0(8'h3A, 1'b0, 1'b0, d, v);
        total++;
        if (d !== exp_rd(8'h3A, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL ce_high_array: got %h expected %h", d, exp_rd(8'h3A, 1'b0, 1'b0));
        end
    endtask

    task automatic test_rd_lat2();
        logic [15:0] d0, d2;
        logic        v0, v2;
        logic [2:0]  rdy;
        do_read2(8'h3A, 1'b0, 1'b0, d0, v0, d2, v2, rdy);
        total++;
        if ({rdy, d2, v2} !== {3'b001, exp_rd(8'h3A, 1'b0, 1'b0), 1'b1}) begin
            bad++;
            $display("FAIL lat2_read: got ready=%b d=%h v=%b expected ready=001 d=%h v=1",
                     rdy, d2, v2, exp_rd(8'h3A, 1'b0, 1'b0));
        end
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0; Addr = 8'h05;
        tick();
        tick();
        total++;
        if ({ready2, valid2} !== 2'b00) begin
            bad++;
            $display("FAIL lat2_waiting: got r=%b v=%b expected r=0 v=0", ready2, valid2);
        end
        bus_idle();
        tick();
        total++;
        if ({ready2, valid2, dout2} !== {1'b1, 1'b0, exp_rd(8'h3A, 1'b0, 1'b0)}) begin
            bad++;
            $display("FAIL lat2_abort: got r=%b v=%b d=%h expected r=1 v=0 d=%h",
                     ready2, valid2, dout2, exp_rd(8'h3A, 1'b0, 1'b0));
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [15:0] d;
        logic        v;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Addr = 8'h10; Data_in = 16'h5555;
        tick(); tick();
        bus_idle();
        tick(); tick();
        model_mem[8'h10] = 16'h5555;
        total++;
        if ({err0, err2, valid0} !== 3'b110) begin
            bad++;
            $display("FAIL conflict_flag: got e0=%b e2=%b v0=%b expected 1 1 0", err0, err2, valid0);
        end
        do_read0(8'h10, 1'b0, 1'b0, d, v);
        total++;
        if (d !== 16'h5555) begin
            bad++;
            $display("FAIL conflict_write_wins: got %h expected 5555", d);
        end
        do_write(8'h11, 16'h0F0F, 1'b0, 1'b0);
        do_read0(8'h11, 1'b0, 1'b0, d, v);
        total++;
        if ({err0, err2, d} !== {1'b1, 1'b1, 16'h0F0F}) begin
            bad++;
            $display("FAIL conflict_sticky: got e0=%b e2=%b d=%h expected 1 1 0f0f", err0, err2, d);
        end
    endtask

    task automatic test_random();
        logic [15:0] d0, d2, exp;
        logic        v0, v2, ub, lb;
        logic [2:0]  rdy;
        logic [7:0]  a;
        for (int i = 0; i < 8; i++) begin
            addr_list[i] = 8'($urandom_range(0, 255));
            do_write(addr_list[i], 16'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a  = addr_list[$urandom_range(0, 7)];
            ub = 1'($urandom);
            lb = 1'($urandom);
            case ($urandom_range(0, 2))
                0: do_write(a, 16'($urandom), ub, lb);
                1: begin
                    exp = exp_rd(a, ub, lb);
                    do_read0(a, ub, lb, d0, v0);
                    total++;
                    if ({d0, v0} !== {exp, 1'b1}) begin
                        bad++;
                        $display("FAIL rand_read0 #%0d a=%h ub=%b lb=%b: got d=%h v=%b expected d=%h v=1",
                                 i, a, ub, lb, d0, v0, exp);
                    end
                end
                default: begin
                    exp = exp_rd(a, ub, lb);
                    do_read2(a, ub, lb, d0, v0, d2, v2, rdy);
                    total++;
                    if ({d0, v0, d2, v2, rdy} !== {exp, 1'b1, exp, 1'b1, 3'b001}) begin
                        bad++;
                        $display("FAIL rand_read2 #%0d a=%h: got d0=%h v0=%b d2=%h v2=%b rdy=%b expected %h 1 %h 1 001",
                                 i, a, d0, v0, d2, v2, rdy, exp, exp);
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0; Addr = 8'h10;
        tick();
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({dout0, valid0, ready0, err0} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_lat0: got d=%h v=%b r=%b e=%b expected d=0000 v=0 r=1 e=0", dout0, valid0, ready0, err0);
        end
        total++;
        if ({dout2, valid2, ready2, err2} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_lat2: got d=%h v=%b r=%b e=%b expected d=0000 v=0 r=1 e=0", dout2, valid2, ready2, err2);
        end
        bus_idle();
        #1 Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_wr_commit();
        logic [15:0] d, old;
        logic        v;
        old = model_mem[addr_list[0]];
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Addr = addr_list[0]; Data_in = ~old;
        tick();
        Reset = 1'b0;
        #1 bus_idle();
        #1 Reset = 1'b1;
        tick(); tick();
        do_read0(addr_list[0], 1'b0, 1'b0, d, v);
        total++;
        if (d !== old) begin
            bad++;
            $display("FAIL reset_wr_commit: got %h expected %h", d, old);
        end
    endtask

    task automatic test_reset_rd_wait();
        logic [15:0] d0, d2;
        logic        v0, v2;
        logic [2:0]  rdy;
        do_write(addr_list[1], 16'hC3A5, 1'b0, 1'b0);
        do_read2(addr_list[1], 1'b0, 1'b0, d0, v0, d2, v2, rdy);
        total++;
        if (d2 !== 16'hC3A5) begin
            bad++;
            $display("FAIL rd_wait_preload: got %h expected c3a5", d2);
        end
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0; Addr = addr_list[1];
        tick();
        Reset = 1'b0;
        #1;
        total++;
        if ({dout2, valid2, ready2} !== {16'h0000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_rd_wait: got d=%h v=%b r=%b expected d=0000 v=0 r=1", dout2, valid2, ready2);
        end
        bus_idle();
        #1 Reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_lanes();
        test_ce_high();
        test_rd_lat2();
        test_conflict();
        test_random();
        test_reset_mid();
        test_reset_wr_commit();
        test_reset_rd_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable on-chip memory target that answers the active-low SRAM strobes (Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB) driven by the SLC-3 control unit. It replaces the board SRAM in simulation and FPGA-only builds, so the CPU datapath runs unchanged. It latches address and write data on strobe assertion, commits byte-lane-masked writes, and returns registered read data in time for the control unit's two-cycle read window.

## Interface
- ADDR_W, 8: word-address width; depth is 2**ADDR_W 16-bit words.
- RD_LAT, 0: extra read wait cycles (0–3). Only 0 meets the control unit's fixed two-cycle OE window; nonzero is for wait-state testing only.
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- Mem_CE  input  1  chip enable, active-low.
- Mem_OE  input  1  output enable (read strobe), active-low.
- Mem_WE  input  1  write enable, active-low.
- Mem_UB  input  1  upper-byte lane enable [15:8], active-low.
- Mem_LB  input  1  lower-byte lane enable [7:0], active-low.
- Addr  input  ADDR_W  word address; upper CPU address bits are dropped by the wrapper.
- Data_in  input  16  write data from the MDR.
- Data_out  output  16  registered read data.
- Data_valid  output  1  high while Data_out holds the result of the current read.
- Ready  output  1  low while a read is waiting in RD_WAIT.
- Err_conflict  output  1  sticky flag: OE and WE were sampled low together.

## Operation
- An access is *requested* when Mem_CE=0 and (Mem_OE=0 or Mem_WE=0) are sampled at a rising edge.
- IDLE:
  - Write request (WE=0): latch Addr, Data_in, UB and LB; go to WR_COMMIT.
  - Read request only (OE=0, WE=1):
    - RD_LAT=0: Data_out <= lane-masked mem[Addr]; Data_valid <= 1; go to HOLD.
    - Otherwise: latch Addr; load counter with RD_LAT; go to RD_WAIT.
- RD_WAIT:
  - If OE, CE and WE are all still asserted as at entry, decrement the counter.
  - When the counter reaches 0, load Data_out and Data_valid as above; go to HOLD.
  - If OE=1 or CE=1 is sampled first, abort to IDLE. Data_out and Data_valid are unchanged.
- WR_COMMIT:
  - Write the latched data into the latched address, per lane: lane written only when its enable is low.
  - Go to HOLD. The commit happens even if the strobes were released this cycle.
- HOLD:
  - Stay until CE=1, or OE=1 and WE=1, is sampled; then go to IDLE.
  - Data_valid clears on the exit edge.
  - No new access starts without passing through IDLE (at least one idle cycle between accesses).
- Read lane masking: a byte whose lane enable is high returns 8'h00.
- Simultaneous OE=0 and WE=0 in IDLE: the write wins; set Err_conflict.
  - Err_conflict is cleared only by Reset.
- CE=1 forces no request, whatever OE and WE are.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values:
  - Data_out = 16'h0000, Data_valid = 0, Ready = 1, Err_conflict = 0, state = IDLE.
  - Reset has effect immediately (asynchronous), independent of Clk.
- Read, RD_LAT=0:
  - OE is low during cycle c0 and is sampled at edge e0.
  - Data_out is valid from e0 through cycle c1, ready for the MDR load at edge e1.
  - Total latency from request edge to data: 0 wait cycles.
- Read, RD_LAT=N: Ready=0 for N cycles after e0; data is valid after edge e0+N.
- Write:
  - WE low in c0 and c1; data latched at e0; array updated at e1.
  - A read of the same address starting at e2 or later returns the new data.
- Reset during WR_COMMIT, before e1: no array write occurs.
- Reset during RD_WAIT: Data_valid=0; Data_out=0.
- Address wrap: Addr is exactly ADDR_W bits wide, so there is no out-of-range case.

## Test plan
- Reset with Reset=0 mid-simulation: all outputs reach their reset values immediately, before the next edge, and state=IDLE.
- Write 16'hBEEF to address 8'h3A (UB=LB=0, WE low for 2 cycles), then read 8'h3A (OE low for 2 cycles) -> Data_out=16'hBEEF with Data_valid=1 in the second OE cycle.
- Byte lanes: write 16'h1234 to 8'h05; write 16'hAB00 with UB=0, LB=1; read with UB=0, LB=0 -> 16'hAB34; read with UB=1, LB=0 -> 16'h0034.
- Conflict: OE=WE=CE=0 with Data_in=16'h5555 at 8'h10 -> array holds 16'h5555 and Err_conflict=1; it stays 1 after later clean accesses until Reset.
- RD_LAT=2: read request -> Ready=0 for 2 cycles, then data valid. Releasing OE after 1 wait cycle -> abort to IDLE, Data_valid stays 0, Data_out keeps its old value.
- CE=1 with OE=WE=0 for 4 cycles -> array unchanged, no Data_valid, no Err_conflict; state stays IDLE.
